// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel coordinates, latency-matched sync/blank,
// colour masking during blanking, line/frame markers and a wrapping frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10,
  parameter int CNT_W    = 11,
  parameter int LAT      = 2
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iEN,
  input  logic [CW-1:0]    iRed,
  input  logic [CW-1:0]    iGreen,
  input  logic [CW-1:0]    iBlue,
  output logic [CNT_W-1:0] px,
  output logic [CNT_W-1:0] py,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count,
  output logic [CW-1:0]    VGA_R,
  output logic [CW-1:0]    VGA_G,
  output logic [CW-1:0]    VGA_B,
  output logic             VGA_H_SYNC,
  output logic             VGA_V_SYNC,
  output logic             VGA_BLANK,
  output logic             VGA_SYNC
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef struct packed {
    logic vid;
    logic hs;
    logic vs;
  } tap_t;

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             h_last, v_last;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [CW-1:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic             blank_q, blank_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  tap_t             cur_tap;
  tap_t             tap_out;

  assign h_last = (hcnt_q == H_LAST);
  assign v_last = (vcnt_q == V_LAST);

  assign video_on    = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
  assign cur_tap.vid = video_on;
  assign cur_tap.hs  = (hcnt_q >= HS_BEG) && (hcnt_q <= HS_END);
  assign cur_tap.vs  = (vcnt_q >= VS_BEG) && (vcnt_q <= VS_END);

  // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    blank_d       = blank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    if (iEN) begin
      if (h_last) begin
        hcnt_d       = '0;
        vcnt_d       = v_last ? '0 : vcnt_q + ONE;
        line_start_d = 1'b1;
        if (v_last) begin
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end else begin
        hcnt_d = hcnt_q + ONE;
      end
      // Colour is taken on the same edge that the delayed blank for its coordinate arrives.
      blank_d = tap_out.vid;
      r_d     = tap_out.vid ? iRed   : '0;
      g_d     = tap_out.vid ? iGreen : '0;
      b_d     = tap_out.vid ? iBlue  : '0;
      hsync_d = tap_out.hs ? H_POL : ~H_POL;
      vsync_d = tap_out.vs ? V_POL : ~V_POL;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      blank_q       <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  if (LAT == 0) begin : g_no_dly
    assign tap_out = cur_tap;
  end else begin : g_dly
    tap_t [LAT-1:0] dly_q, dly_d;

    always_comb begin
      dly_d = dly_q;
      if (iEN) begin
        dly_d[0] = cur_tap;
        for (int i = 1; i < LAT; i++) dly_d[i] = dly_q[i-1];
      end
    end

    // NOTE: the delay stages are reset (unlike a data RAM) so a mid-frame reset cannot push stale blank/sync to the pins.
    always_ff @(posedge iCLK) begin
      if (!iRST_N) dly_q <= '0;
      else         dly_q <= dly_d;
    end

    assign tap_out = dly_q[LAT-1];
  end

  assign px          = hcnt_q;
  assign py          = vcnt_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_BLANK   = blank_q;
  assign VGA_H_SYNC  = hsync_q;
  assign VGA_V_SYNC  = vsync_q;
  assign VGA_SYNC    = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance with a 2-deep pixel
// source and a tiny 15x7 instance (LAT=0, active-high syncs), each run free and with iEN toggling.
module tb_vga_timing_gen;

  logic clk;
  int   n_chk;
  int   n_fail;

  // ---------------- instance A: defaults ----------------
  logic        rst_a, en_a;
  logic [9:0]  red_a, grn_a, blu_a;
  logic [10:0] px_a, py_a;
  logic        vid_a, ls_a, fs_a;
  logic [15:0] fc_a;
  logic [9:0]  r_a, g_a, b_a;
  logic        hs_a, vs_a, blank_a, sync_a;
  logic [9:0]  src1 = '0;
  logic [9:0]  src2 = '0;

  // ---------------- instance B: 8/2/3/2 x 4/1/1/1 ----------------
  logic        rst_b, en_b;
  logic [9:0]  red_b, grn_b, blu_b;
  logic [10:0] px_b, py_b;
  logic        vid_b, ls_b, fs_b;
  logic [15:0] fc_b;
  logic [9:0]  r_b, g_b, b_b;
  logic        hs_b, vs_b, blank_b, sync_b;

  vga_timing_gen dut_a (
    .iCLK(clk), .iRST_N(rst_a), .iEN(en_a),
    .iRed(red_a), .iGreen(grn_a), .iBlue(blu_a),
    .px(px_a), .py(py_a), .video_on(vid_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .VGA_H_SYNC(hs_a), .VGA_V_SYNC(vs_a), .VGA_BLANK(blank_a), .VGA_SYNC(sync_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .LAT(0)
  ) dut_b (
    .iCLK(clk), .iRST_N(rst_b), .iEN(en_b),
    .iRed(red_b), .iGreen(grn_b), .iBlue(blu_b),
    .px(px_b), .py(py_b), .video_on(vid_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .VGA_H_SYNC(hs_b), .VGA_V_SYNC(vs_b), .VGA_BLANK(blank_b), .VGA_SYNC(sync_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel source for A: echoes px[9:0] two enabled cycles later.
  always @(posedge clk) begin
    if (en_a) begin
      src1 <= px_a[9:0];
      src2 <= src1;
    end
  end
  assign red_a = src2;
  assign grn_a = 10'h155;
  assign blu_a = 10'h2AA;

  // Pixel source for B: zero latency, colour encodes the current coordinate.
  assign red_b = {px_b[4:0], py_b[4:0]};
  assign grn_b = ~{px_b[4:0], py_b[4:0]};
  assign blu_b = 10'h2AA;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // e = enabled edges since reset release; last = whether the latest edge was enabled.
  task automatic chk_a(input string ph, input int e, input bit last);
    int c, h, v;
    bit vis, hs_act, vs_act;
    string t;
    t = $sformatf("%s e=%0d", ph, e);
    vis = 0; hs_act = 0; vs_act = 0; h = 0;
    if (e >= 3) begin
      c      = e - 3;
      h      = c % 800;
      v      = (c / 800) % 525;
      vis    = (h < 640) && (v < 480);
      hs_act = (h >= 656) && (h <= 751);
      vs_act = (v >= 490) && (v <= 491);
    end
    check({t, " px"},    32'(px_a),    e % 800);
    check({t, " py"},    32'(py_a),    (e / 800) % 525);
    check({t, " vid"},   32'(vid_a),   ((e % 800) < 640 && ((e / 800) % 525) < 480) ? 1 : 0);
    check({t, " blank"}, 32'(blank_a), vis ? 1 : 0);
    check({t, " R"},     32'(r_a),     vis ? h : 0);
    check({t, " G"},     32'(g_a),     vis ? 32'h155 : 0);
    check({t, " B"},     32'(b_a),     vis ? 32'h2AA : 0);
    check({t, " hs"},    32'(hs_a),    hs_act ? 0 : 1);
    check({t, " vs"},    32'(vs_a),    vs_act ? 0 : 1);
    check({t, " ls"},    32'(ls_a),    (last && e > 0 && e % 800 == 0) ? 1 : 0);
    check({t, " fs"},    32'(fs_a),    (last && e > 0 && e % 420000 == 0) ? 1 : 0);
    check({t, " fc"},    32'(fc_a),    (e / 420000) % 65536);
    check({t, " sync"},  32'(sync_a),  0);
  endtask

  task automatic chk_b(input string ph, input int e, input bit last);
    int c, h, v;
    bit vis, hs_act, vs_act;
    string t;
    t = $sformatf("%s e=%0d", ph, e);
    vis = 0; hs_act = 0; vs_act = 0; h = 0; v = 0;
    if (e >= 1) begin
      c      = e - 1;
      h      = c % 15;
      v      = (c / 15) % 7;
      vis    = (h < 8) && (v < 4);
      hs_act = (h >= 10) && (h <= 12);
      vs_act = (v == 5);
    end
    check({t, " px"},    32'(px_b),    e % 15);
    check({t, " py"},    32'(py_b),    (e / 15) % 7);
    check({t, " vid"},   32'(vid_b),   ((e % 15) < 8 && ((e / 15) % 7) < 4) ? 1 : 0);
    check({t, " blank"}, 32'(blank_b), vis ? 1 : 0);
    check({t, " R"},     32'(r_b),     vis ? ((h << 5) | v) : 0);
    check({t, " G"},     32'(g_b),     vis ? (~((h << 5) | v) & 32'h3FF) : 0);
    check({t, " B"},     32'(b_b),     vis ? 32'h2AA : 0);
    check({t, " hs"},    32'(hs_b),    hs_act ? 1 : 0);
    check({t, " vs"},    32'(vs_b),    vs_act ? 1 : 0);
    check({t, " ls"},    32'(ls_b),    (last && e > 0 && e % 15 == 0) ? 1 : 0);
    check({t, " fs"},    32'(fs_b),    (last && e > 0 && e % 105 == 0) ? 1 : 0);
    check({t, " fc"},    32'(fc_b),    (e / 105) % 65536);
    check({t, " sync"},  32'(sync_b),  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    n_chk  = 0;
    n_fail = 0;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    en_a   = 1'b1;
    en_b   = 1'b1;
    repeat (3) step();

    // A: free-running from reset release, two lines plus.
    rst_a = 1'b1;
    chk_a("a_rst", 0, 1'b0);
    for (int k = 1; k <= 1700; k++) begin
      step();
      chk_a("a_run", k, 1'b1);
    end

    // A: reset mid-line while visible colour (R=97) is on the pins.
    rst_a = 1'b0;
    step();
    chk_a("a_midrst", 0, 1'b0);
    rst_a = 1'b1;

    // A: iEN alternating; pipeline must flush stale source colour after reset.
    e = 0;
    for (int j = 0; j < 1620; j++) begin
      en_a = (j % 2 == 0);
      step();
      if (en_a) e++;
      chk_a("a_tog", e, en_a);
    end
    en_a = 1'b1;

    // B: small frame, LAT=0, active-high syncs, beyond two full frames.
    rst_b = 1'b1;
    chk_b("b_rst", 0, 1'b0);
    for (int k = 1; k <= 230; k++) begin
      step();
      chk_b("b_run", k, 1'b1);
    end

    // B: reset mid-frame with frame_count=2 and colour on the pins.
    rst_b = 1'b0;
    step();
    chk_b("b_midrst", 0, 1'b0);
    rst_b = 1'b1;

    // B: iEN alternating across a frame wrap.
    e = 0;
    for (int j = 0; j < 240; j++) begin
      en_b = (j % 2 == 0);
      step();
      if (en_b) e++;
      chk_b("b_tog", e, en_b);
    end
    en_b = 1'b1;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and output stage, the successor of the fixed-640x480 sync block in the VGA interface. It produces pixel coordinates for a pixel source, delays sync and blank by a configurable source latency so they stay aligned with the returned colour, masks colour during blanking, and adds frame/line markers and a frame counter. It sits between the pixel generator (e.g. the Razzle display) and the VGA DAC pins, clocked by the VGA control clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- H_POL, 0, HS active level (0 = active-low)
- V_POL, 0, VS active level
- CW, 10, colour channel width
- CNT_W, 11, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
- LAT, 2, pixel-source latency in enabled cycles (0..15)

Ports:
- iCLK  in  1  pixel/control clock; the only clock
- iRST_N  in  1  synchronous active-low reset
- iEN  in  1  pixel enable; all counters and pipeline stages advance only when 1
- iRed, iGreen, iBlue  in  CW each  colour from pixel source for coordinates issued LAT enabled cycles earlier
- px, py  out  CNT_W each  current horizontal/vertical counter
- video_on  out  1  px/py inside the active area
- line_start  out  1  one-cycle pulse, horizontal counter wrapped
- frame_start  out  1  one-cycle pulse, both counters wrapped
- frame_count  out  16  completed frames, wrapping
- VGA_R, VGA_G, VGA_B  out  CW each  masked colour
- VGA_H_SYNC, VGA_V_SYNC  out  1  syncs at configured polarity
- VGA_BLANK  out  1  active-low blank (1 = visible)
- VGA_SYNC  out  1  composite sync, tied 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Every parameter ≥ 1.
- Line/frame order: active, front porch, sync, back porch. Counters start in active region.
- hcnt increments on iEN; at H_TOTAL-1 it wraps to 0 and vcnt increments; vcnt wraps to 0 after V_TOTAL-1.
- px = hcnt, py = vcnt (registered counters, not masked). video_on = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE), combinational from counters.
- Raw hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; raw vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; vs depends only on vcnt (changes at line boundary).
- Delay line: {video_on, hs, vs} shifted through LAT stages advancing on iEN, then one output register. Output register on iEN: VGA_BLANK = delayed video_on; VGA_R/G/B = delayed video_on ? iRed/iGreen/iBlue : 0; VGA_H_SYNC = delayed hs XNOR H_POL... i.e. H_POL when hs active, ~H_POL otherwise; same for VS.
- line_start: registered, high for exactly one iCLK cycle after an enabled cycle in which hcnt wrapped H_TOTAL-1 → 0. frame_start: same, when (hcnt,vcnt) wrapped (H_TOTAL-1,V_TOTAL-1) → (0,0); frame_start implies line_start. frame_count increments in the same cycle frame_start rises, wraps 0xFFFF → 0.
- iEN low: counters, delay line, outputs hold; pulses drop to 0 after one cycle and never repeat for the same wrap.

## Timing
- Reset (iRST_N low at an iCLK edge, regardless of iEN): hcnt = vcnt = 0, all delay stages = {video_on 0, hs 0, vs 0}, VGA_R/G/B = 0, VGA_BLANK = 0, VGA_H_SYNC = ~H_POL, VGA_V_SYNC = ~V_POL, line_start = frame_start = 0, frame_count = 0. video_on after reset = 1 (counters at 0,0). No frame_start for the first frame after reset.
- Reset mid-frame: restarts at (0,0) next cycle; delay line flushed, no stale colour or sync reaches pins.
- Output latency: counter value to VGA pins = LAT+1 enabled cycles; colour sampled on the same edge that the delayed video_on for that coordinate reaches the output register.
- LAT = 0: output register samples iRed/G/B combinationally aligned with current px/py.
- Throughput: one pixel per enabled cycle; no back-pressure.

## Test plan
- Defaults, iEN=1, release reset at cycle 0: VGA_H_SYNC falls at cycle 656+3 and rises at 752+3; VGA_BLANK first falls at 640+3; period 800 cycles.
- Defaults, full frame: VGA_V_SYNC low during lines 490-491 (delayed 3 cycles), frame_start pulses every 420000 cycles, frame_count = 2 after two full frames.
- Pixel source echoing px[9:0] on iRed with 2-cycle latency: VGA_R equals horizontal position for 0..639 on every visible line, 0 in all blanking.
- iEN toggled 1/0 alternately: all output timings exactly double; line_start/frame_start stay one iCLK wide.
- Parameters 8/2/3/2 × 4/1/1/1, H_POL=V_POL=1, LAT=0: HS high at hcnt 10-12 with 1-cycle latency, H_TOTAL 15, V_TOTAL 7.
- Reset asserted at hcnt=300, vcnt=200 with colour nonzero: next cycle px=py=0, VGA_R/G/B=0, VGA_BLANK=0, syncs inactive; frame_count=0.
